demux2way32b_buf: RTL and testbench

DEMUX2WAY32B_BUF -- requirements
Module: demux2way32b_buf

---
 rtl/demux2way32b_buf.sv | 99 +++++++++
 tb/tb_demux2way32b_buf.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/demux2way32b_buf.sv
// Two-way demultiplexer with a small FIFO per output port.
// Each queue tracks its occupancy and a wrapping count of delivered words.
module demux2way32b_buf #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_address,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     out0_valid,
  output logic                     out1_valid,
  input  logic                     out0_ready,
  input  logic                     out1_ready,
  output logic [WIDTH-1:0]         out0_data,
  output logic [WIDTH-1:0]         out1_data,
  output logic [$clog2(DEPTH):0]   count0,
  output logic [$clog2(DEPTH):0]   count1,
  output logic [7:0]               xfer0,
  output logic [7:0]               xfer1
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic             ready_s [2];
  logic             valid_s [2];
  logic [CW-1:0]    cnt_s   [2];
  logic [7:0]       xfer_s  [2];
  logic [WIDTH-1:0] head_s  [2];

  assign ready_s[0] = out0_ready;
  assign ready_s[1] = out1_ready;

  // Full check uses only the registered count of the addressed queue.
  assign in_ready = (cnt_s[in_address] != CW'(DEPTH));

  genvar g;
  generate
    for (g = 0; g < 2; g++) begin : g_q
      logic [WIDTH-1:0] mem_r [DEPTH];
      logic [AW-1:0]    wr_ptr_r;
      logic [AW-1:0]    rd_ptr_r;
      logic [CW-1:0]    cnt_r;
      logic [7:0]       xfer_r;
      logic             push_s;
      logic             pop_s;

      assign push_s     = in_valid & in_ready & (in_address == 1'(g));
      assign pop_s      = valid_s[g] & ready_s[g];
      assign valid_s[g] = (cnt_r != CW'(0));
      assign cnt_s[g]   = cnt_r;
      assign xfer_s[g]  = xfer_r;
      assign head_s[g]  = valid_s[g] ? mem_r[rd_ptr_r] : {WIDTH{1'b0}};

      // Pointer, occupancy and delivery-count state; reset discards queued words.
      always_ff @(posedge clk) begin
        if (reset) begin
          wr_ptr_r <= AW'(0);
          rd_ptr_r <= AW'(0);
          cnt_r    <= CW'(0);
          xfer_r   <= 8'd0;
        end else begin
          if (push_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
          end
          if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
            xfer_r   <= xfer_r + 8'd1;
          end
          if (push_s && !pop_s) begin
            cnt_r <= cnt_r + CW'(1);
          end else if (!push_s && pop_s) begin
            cnt_r <= cnt_r - CW'(1);
          end
        end
      end

      // Storage needs no reset: the head is masked to zero while the queue is empty.
      always_ff @(posedge clk) begin
        if (push_s) begin
          mem_r[wr_ptr_r] <= in_data;
        end
      end
    end
  endgenerate

  assign out0_valid = valid_s[0];
  assign out1_valid = valid_s[1];
  assign out0_data  = head_s[0];
  assign out1_data  = head_s[1];
  assign count0     = cnt_s[0];
  assign count1     = cnt_s[1];
  assign xfer0      = xfer_s[0];
  assign xfer1      = xfer_s[1];

endmodule

// File: tb/tb_demux2way32b_buf.sv
// Randomized and directed bench for demux2way32b_buf against a queue-based model.
module tb_demux2way32b_buf;

  localparam int WIDTH = 32;
  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic             in_address;
  logic [WIDTH-1:0] in_data;
  logic             out0_valid, out1_valid;
  logic             out0_ready, out1_ready;
  logic [WIDTH-1:0] out0_data, out1_data;
  logic [CW-1:0]    count0, count1;
  logic [7:0]       xfer0, xfer1;

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  logic [WIDTH-1:0] q0 [$];
  logic [WIDTH-1:0] q1 [$];
  int x0 = 0;
  int x1 = 0;

  demux2way32b_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_address(in_address), .in_data(in_data),
    .out0_valid(out0_valid), .out1_valid(out1_valid),
    .out0_ready(out0_ready), .out1_ready(out1_ready),
    .out0_data(out0_data), .out1_data(out1_data),
    .count0(count0), .count1(count1), .xfer0(xfer0), .xfer1(xfer1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: each port is a plain bounded FIFO of words.
  always @(posedge clk) begin
    bit pu0, pu1, po0, po1;
    started <= 1'b1;
    if (reset) begin
      q0.delete();
      q1.delete();
      x0 = 0;
      x1 = 0;
    end else begin
      pu0 = in_valid && (in_address == 1'b0) && (q0.size() < DEPTH);
      pu1 = in_valid && (in_address == 1'b1) && (q1.size() < DEPTH);
      po0 = out0_ready && (q0.size() > 0);
      po1 = out1_ready && (q1.size() > 0);
      if (po0) begin void'(q0.pop_front()); x0 = (x0 + 1) % 256; end
      if (po1) begin void'(q1.pop_front()); x1 = (x1 + 1) % 256; end
      if (pu0) q0.push_back(in_data);
      if (pu1) q1.push_back(in_data);
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (started) begin
      int sz;
      sz = (in_address == 1'b0) ? q0.size() : q1.size();
      chk("in_ready",   32'(in_ready),   32'(sz != DEPTH));
      chk("out0_valid", 32'(out0_valid), 32'(q0.size() != 0));
      chk("out1_valid", 32'(out1_valid), 32'(q1.size() != 0));
      chk("out0_data",  out0_data, (q0.size() != 0) ? q0[0] : 32'h0);
      chk("out1_data",  out1_data, (q1.size() != 0) ? q1[0] : 32'h0);
      chk("count0",     32'(count0), 32'(q0.size()));
      chk("count1",     32'(count1), 32'(q1.size()));
      chk("xfer0",      32'(xfer0),  32'(x0));
      chk("xfer1",      32'(xfer1),  32'(x1));
    end
  end

  task automatic set(input logic rs, input logic v, input logic a, input logic [31:0] d,
                     input logic r0, input logic r1);
    reset      = rs;
    in_valid   = v;
    in_address = a;
    in_data    = d;
    out0_ready = r0;
    out1_ready = r1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    set(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    tick(); tick();
    set(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out0_valid", 32'(out0_valid), 32'd0);
    chk("rst_out1_data", out1_data, 32'h0);

    // Scenario 1: single push to port 0.
    set(1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0);
    tick();
    set(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("s1_out0_valid", 32'(out0_valid), 32'd1);
    chk("s1_out0_data", out0_data, 32'hDEADBEEF);
    chk("s1_count0", 32'(count0), 32'd1);
    chk("s1_out1_valid", 32'(out1_valid), 32'd0);
    chk("s1_out1_data", out1_data, 32'h0);
    set(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    tick();

    // Scenario 2: fill port 1, third word refused, then drain in order.
    set(1'b0, 1'b1, 1'b1, 32'h1, 1'b0, 1'b0); tick();
    set(1'b0, 1'b1, 1'b1, 32'h2, 1'b0, 1'b0); tick();
    set(1'b0, 1'b1, 1'b1, 32'h3, 1'b0, 1'b0); #1;
    chk("s2_count1", 32'(count1), 32'd2);
    chk("s2_in_ready", 32'(in_ready), 32'd0);
    tick();
    set(1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1); #1;
    chk("s2_head1", out1_data, 32'h1);
    tick();
    chk("s2_head2", out1_data, 32'h2);
    tick();
    chk("s2_empty", 32'(count1), 32'd0);
    chk("s2_xfer1", 32'(xfer1), 32'd2);

    // Scenario 3: port 0 full blocks only port 0.
    set(1'b0, 1'b1, 1'b0, 32'h30, 1'b0, 1'b0); tick();
    set(1'b0, 1'b1, 1'b0, 32'h31, 1'b0, 1'b0); tick();
    set(1'b0, 1'b1, 1'b0, 32'h32, 1'b0, 1'b0); #1;
    chk("s3_ready_a0", 32'(in_ready), 32'd0);
    set(1'b0, 1'b1, 1'b1, 32'hA5A5A5A5, 1'b0, 1'b0); #1;
    chk("s3_ready_a1", 32'(in_ready), 32'd1);
    tick();
    chk("s3_count1", 32'(count1), 32'd1);
    chk("s3_out1_data", out1_data, 32'hA5A5A5A5);
    chk("s3_out0_data", out0_data, 32'h30);
    set(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1); tick(); tick();

    // Scenario 4: simultaneous push and pop keeps occupancy.
    set(1'b0, 1'b1, 1'b0, 32'h10, 1'b0, 1'b0); tick();
    set(1'b0, 1'b1, 1'b0, 32'h11, 1'b1, 1'b0); tick();
    set(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("s4_count0", 32'(count0), 32'd1);
    chk("s4_out0_data", out0_data, 32'h11);
    set(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0); tick();

    // Scenario 5: reset with both queues full and a push presented.
    for (int i = 0; i < 4; i++) begin
      set(1'b0, 1'b1, 1'(i % 2), 32'h50 + 32'(i), 1'b0, 1'b0);
      tick();
    end
    chk("s5_full0", 32'(count0), 32'd2);
    chk("s5_full1", 32'(count1), 32'd2);
    set(1'b1, 1'b1, 1'b0, 32'h5F, 1'b0, 1'b0); tick();
    set(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0); #1;
    chk("s5_count0", 32'(count0), 32'd0);
    chk("s5_count1", 32'(count1), 32'd0);
    chk("s5_valid0", 32'(out0_valid), 32'd0);
    chk("s5_data1", out1_data, 32'h0);
    chk("s5_in_ready", 32'(in_ready), 32'd1);
    chk("s5_xfer1", 32'(xfer1), 32'd0);
    tick();
    chk("s5_absent", 32'(count0), 32'd0);

    // Scenario 6: 256 words through port 0 wraps the delivery count.
    for (int i = 0; i < 256; i++) begin
      set(1'b0, 1'b1, 1'b0, 32'(i), 1'b1, 1'b0);
      tick();
      if (i == 200) chk("s6_xfer0_mid", 32'(xfer0), 32'd200);
    end
    set(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0); tick();
    chk("s6_xfer0_wrap", 32'(xfer0), 32'd0);
    chk("s6_count0", 32'(count0), 32'd0);

    // Random traffic, per-cycle scoreboard comparison.
    for (int i = 0; i < 3000; i++) begin
      set(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 7), 1'($urandom),
          $urandom, ($urandom_range(0, 9) < 5), ($urandom_range(0, 9) < 5));
      tick();
    end

    set(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    tick(); tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
